bus_arbiter: RTL and testbench
==============================

Name: bus_arbiter

Overview:
Owns the shared system bus (bus_addr/bus_wdata/bus_size/bus_write) between the CPU and the four DMA channels. It replaces the direct CPU/DMA wiring onto the memory controller. It grants the bus under fixed GBA priority (DMA0 > DMA1 > DMA2 > DMA3 > CPU) and changes owner only at transfer boundaries. It drives the CPU stall (dmaActive) and a per-channel one-hot grant, and inserts a one-cycle turnaround on every owner change.

Parameters:
NUM_DMA, 4, number of DMA requesters; channel 0 has highest priority
ADDR_W, 32, bus address/data width
CNT_W, 16, width of the per-grant beat counter

Ports:
clock  in  1  system clock (gba_clk)
reset  in  1  asynchronous, active-high reset
cpu_addr  in  ADDR_W  CPU request address
cpu_wdata  in  ADDR_W  CPU write data
cpu_size  in  2  CPU transfer size
cpu_write  in  1  CPU write enable
dma_req  in  NUM_DMA  per-channel bus request, level, held for whole burst
dma_addr  in  NUM_DMA*ADDR_W  packed per-channel address, channel i at [i*ADDR_W +: ADDR_W]
dma_wdata  in  NUM_DMA*ADDR_W  packed per-channel write data
dma_size  in  NUM_DMA*2  packed per-channel size
dma_write  in  NUM_DMA  per-channel write enable
bus_pause  in  1  memory wait; high = current beat not complete
bus_addr  out  ADDR_W  muxed address to mem_top
bus_wdata  out  ADDR_W  muxed write data
bus_size  out  2  muxed size
bus_write  out  1  muxed write enable
dma_grant  out  NUM_DMA  one-hot grant, registered
beat_done  out  1  owner's beat completed this cycle (owner valid & !bus_pause)
dma_active  out  1  high whenever the CPU does not own the bus (to CPU dmaActive)
beat_count  out  CNT_W  beats completed in the current DMA grant (debug/LED)

Behaviour:
- States: CPU_OWN, TURN, DMA_OWN. Reset is asynchronous and active-high and forces:
  - state=CPU_OWN, dma_grant=0, dma_active=0, beat_count=0, next-owner register=0.
  - beat_done is combinational from state and bus_pause, so it equals !bus_pause under reset.
- Bus mux, combinational from registered state:
  - CPU_OWN: bus_* = cpu_*.
  - DMA_OWN: bus_* = fields of the granted channel.
  - TURN: bus_write=0, bus_size=2'b00; bus_addr and bus_wdata hold the last owner's values, so no spurious write reaches memory.
- Priority encoder: highest pending = lowest index i with dma_req[i]=1.
- CPU_OWN -> TURN when |dma_req and !bus_pause. The CPU beat completes in that cycle; the encoder result is latched as next owner.
  - If bus_pause=1, stay in CPU_OWN until the beat completes.
- TURN lasts exactly 1 cycle:
  - If the latched channel still requests, go to DMA_OWN with dma_grant=onehot(latched), beat_count=0.
  - If the latched channel dropped but another channel requests, re-encode and go to DMA_OWN with the new highest.
  - If no channel requests, go to CPU_OWN.
- DMA_OWN, on each cycle with !bus_pause (beat boundary):
  - beat_count increments, saturating at all-ones.
  - If a strictly higher-priority channel requests, or the owner's dma_req=0: go to TURN, latching the new highest pending channel (or none).
  - Otherwise stay in DMA_OWN.
- DMA_OWN with bus_pause=1: no transition, grant held, even if a higher channel asserts or the owner drops req mid-beat.
- dma_active = (state != CPU_OWN), registered with the state. The CPU must also stall on bus_pause; the CPU combines both.
- Latency, request to first DMA beat: 2 cycles after the CPU beat completes (TURN, then DMA_OWN).
- Simultaneous requests resolve by priority only; there is no fairness or round-robin (matches GBA hardware).
- Reset mid-burst aborts the grant immediately; no beat completion is reported.

Decomposition:
- Package gba_bus_pkg:
  - owner_t enum (CPU_OWN, TURN, DMA_OWN)
  - size encoding constants (BYTE/HALF/WORD)
  - NUM_DMA default
- Sub-module dma_prio_enc:
  - combinational lowest-index-first encoder
  - outputs: any_req, idx, and a higher_than(idx) mask used for preemption.

Test Plan:
- Reset with dma_req=4'b0000 → dma_grant=0, dma_active=0; bus_addr follows cpu_addr=32'h0300_0000.
- CPU beat with bus_pause=1 for 3 cycles; dma_req[3] rises on the first of them → stays CPU_OWN for 3 cycles, then TURN (bus_write=0), then dma_grant=4'b1000 with bus_addr=dma_addr[3].
- dma_req=4'b1010 asserted together → DMA1 granted first; DMA3 never granted while DMA1 requests.
- DMA3 owns and completes 5 beats; dma_req[0] rises while bus_pause=1 → grant held until the beat ends, then beat_count=5, TURN, then dma_grant=4'b0001 with beat_count=0.
- Owner drops req with no other request pending → TURN, then CPU_OWN; dma_active falls 2 cycles after the final beat.
- Assert reset mid-burst (DMA2, bus_pause=1) → same cycle: dma_grant=0, dma_active=0, bus_* = cpu_*.

Source files
------------

// File: rtl/gba_bus_pkg.sv
// Shared types for the GBA system-bus arbiter: owner states, transfer sizes and the default DMA channel count.
package gba_bus_pkg;

    typedef enum logic [1:0] {
        CPU_OWN = 2'd0,
        TURN    = 2'd1,
        DMA_OWN = 2'd2
    } owner_t;

    typedef enum logic [1:0] {
        SIZE_BYTE = 2'b00,
        SIZE_HALF = 2'b01,
        SIZE_WORD = 2'b10
    } size_t;

    localparam int unsigned NUM_DMA_DEFAULT = 4;

endpackage

// File: rtl/dma_prio_enc.sv
// Fixed-priority DMA request encoder: lowest index wins. Also returns the mask of
// channels that outrank a given owner, for preemption.
module dma_prio_enc #(
    parameter int unsigned N  = 4,
    parameter int unsigned IW = 2
) (
    input  logic [N-1:0]  req,
    input  logic [IW-1:0] own,
    output logic          any_req,
    output logic [IW-1:0] idx,
    output logic [N-1:0]  higher
);

    always_comb begin
        any_req = |req;
        idx     = '0;
        for (int i = int'(N) - 1; i >= 0; i--) begin
            if (req[i]) idx = IW'(i);
        end
        higher = '0;
        for (int i = 0; i < int'(N); i++) begin
            higher[i] = (i < int'(own));
        end
    end

endmodule

// File: rtl/bus_arbiter.sv
// Shared system-bus arbiter between the CPU and the DMA channels: fixed priority,
// owner changes only at beat boundaries, one idle turnaround cycle on every handover.
module bus_arbiter
    import gba_bus_pkg::*;
#(
    parameter int unsigned NUM_DMA = NUM_DMA_DEFAULT,
    parameter int unsigned ADDR_W  = 32,
    parameter int unsigned CNT_W   = 16
) (
    input  logic                    clock,
    input  logic                    reset,
    input  logic [ADDR_W-1:0]       cpu_addr,
    input  logic [ADDR_W-1:0]       cpu_wdata,
    input  logic [1:0]              cpu_size,
    input  logic                    cpu_write,
    input  logic [NUM_DMA-1:0]      dma_req,
    input  logic [NUM_DMA*ADDR_W-1:0] dma_addr,
    input  logic [NUM_DMA*ADDR_W-1:0] dma_wdata,
    input  logic [NUM_DMA*2-1:0]    dma_size,
    input  logic [NUM_DMA-1:0]      dma_write,
    input  logic                    bus_pause,
    output logic [ADDR_W-1:0]       bus_addr,
    output logic [ADDR_W-1:0]       bus_wdata,
    output logic [1:0]              bus_size,
    output logic                    bus_write,
    output logic [NUM_DMA-1:0]      dma_grant,
    output logic                    beat_done,
    output logic                    dma_active,
    output logic [CNT_W-1:0]        beat_count
);

    localparam int unsigned IDX_W = (NUM_DMA > 1) ? $clog2(NUM_DMA) : 1;

    owner_t              state;
    logic [IDX_W-1:0]    own_idx;
    logic [IDX_W-1:0]    nxt_idx;
    logic                nxt_vld;
    logic [ADDR_W-1:0]   last_addr;
    logic [ADDR_W-1:0]   last_wdata;

    logic                any_req;
    logic [IDX_W-1:0]    enc_idx;
    logic [NUM_DMA-1:0]  higher_mask;
    logic                preempt;
    logic                turn_go;
    logic [IDX_W-1:0]    turn_idx;

    logic [ADDR_W-1:0]   ch_addr  [NUM_DMA];
    logic [ADDR_W-1:0]   ch_wdata [NUM_DMA];
    logic [1:0]          ch_size  [NUM_DMA];

    for (genvar g = 0; g < NUM_DMA; g++) begin : g_unpack
        assign ch_addr[g]  = dma_addr[g*ADDR_W +: ADDR_W];
        assign ch_wdata[g] = dma_wdata[g*ADDR_W +: ADDR_W];
        assign ch_size[g]  = dma_size[g*2 +: 2];
    end

    dma_prio_enc #(
        .N  (NUM_DMA),
        .IW (IDX_W)
    ) u_enc (
        .req     (dma_req),
        .own     (own_idx),
        .any_req (any_req),
        .idx     (enc_idx),
        .higher  (higher_mask)
    );

    // Turnaround target: keep the latched channel if it still wants the bus, else re-encode.
    always_comb begin
        preempt  = |(dma_req & higher_mask);
        turn_go  = 1'b0;
        turn_idx = enc_idx;
        if (nxt_vld && dma_req[nxt_idx]) begin
            turn_go  = 1'b1;
            turn_idx = nxt_idx;
        end else if (any_req) begin
            turn_go  = 1'b1;
        end
    end

    // Bus mux; during turnaround address/data hold and no transfer is signalled.
    always_comb begin
        bus_addr  = cpu_addr;
        bus_wdata = cpu_wdata;
        bus_size  = cpu_size;
        bus_write = cpu_write;
        case (state)
            DMA_OWN: begin
                bus_addr  = ch_addr[own_idx];
                bus_wdata = ch_wdata[own_idx];
                bus_size  = ch_size[own_idx];
                bus_write = dma_write[own_idx];
            end
            TURN: begin
                bus_addr  = last_addr;
                bus_wdata = last_wdata;
                bus_size  = SIZE_BYTE;
                bus_write = 1'b0;
            end
            default: ;
        endcase
        beat_done = (state != TURN) && !bus_pause;
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state      <= CPU_OWN;
            dma_grant  <= '0;
            dma_active <= 1'b0;
            beat_count <= '0;
            own_idx    <= '0;
            nxt_idx    <= '0;
            nxt_vld    <= 1'b0;
            last_addr  <= '0;
            last_wdata <= '0;
        end else begin
            if (state != TURN) begin
                last_addr  <= bus_addr;
                last_wdata <= bus_wdata;
            end
            case (state)
                CPU_OWN: begin
                    if (any_req && !bus_pause) begin
                        state      <= TURN;
                        dma_active <= 1'b1;
                        nxt_idx    <= enc_idx;
                        nxt_vld    <= 1'b1;
                    end
                end
                TURN: begin
                    if (turn_go) begin
                        state      <= DMA_OWN;
                        own_idx    <= turn_idx;
                        dma_grant  <= NUM_DMA'(1) << turn_idx;
                        beat_count <= '0;
                    end else begin
                        state      <= CPU_OWN;
                        dma_active <= 1'b0;
                    end
                end
                DMA_OWN: begin
                    if (!bus_pause) begin
                        if (beat_count != '1) beat_count <= beat_count + CNT_W'(1);
                        if (preempt || !dma_req[own_idx]) begin
                            state     <= TURN;
                            dma_grant <= '0;
                            nxt_idx   <= enc_idx;
                            nxt_vld   <= any_req;
                        end
                    end
                end
                default: state <= CPU_OWN;
            endcase
        end
    end

endmodule

// File: tb/tb_bus_arbiter.sv
// Randomized and directed bench for bus_arbiter against a rule-level ownership model.
module tb_bus_arbiter;

    localparam int unsigned N  = 4;
    localparam int unsigned AW = 32;
    localparam int unsigned CW = 16;

    logic            clock = 1'b0;
    logic            reset;
    logic [AW-1:0]   cpu_addr, cpu_wdata;
    logic [1:0]      cpu_size;
    logic            cpu_write;
    logic [N-1:0]    dma_req;
    logic [N*AW-1:0] dma_addr, dma_wdata;
    logic [N*2-1:0]  dma_size;
    logic [N-1:0]    dma_write;
    logic            bus_pause;
    logic [AW-1:0]   bus_addr, bus_wdata;
    logic [1:0]      bus_size;
    logic            bus_write;
    logic [N-1:0]    dma_grant;
    logic            beat_done, dma_active;
    logic [CW-1:0]   beat_count;

    always #5 clock = ~clock;

    bus_arbiter #(.NUM_DMA(N), .ADDR_W(AW), .CNT_W(CW)) dut (
        .clock(clock), .reset(reset),
        .cpu_addr(cpu_addr), .cpu_wdata(cpu_wdata), .cpu_size(cpu_size), .cpu_write(cpu_write),
        .dma_req(dma_req), .dma_addr(dma_addr), .dma_wdata(dma_wdata),
        .dma_size(dma_size), .dma_write(dma_write), .bus_pause(bus_pause),
        .bus_addr(bus_addr), .bus_wdata(bus_wdata), .bus_size(bus_size), .bus_write(bus_write),
        .dma_grant(dma_grant), .beat_done(beat_done), .dma_active(dma_active),
        .beat_count(beat_count)
    );

    int n_checks = 0;
    int n_errors = 0;

    // Model: owner is -1 for CPU or a channel number; in_turn marks the idle handover cycle.
    int          m_owner;
    int          m_next;
    int          m_beats;
    bit          m_in_turn;
    logic [31:0] m_hold_addr, m_hold_wdata;

    task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
        end
    endtask

    function automatic int highest(input logic [N-1:0] r);
        for (int i = 0; i < int'(N); i++) if (r[i]) return i;
        return -1;
    endfunction

    task automatic model_reset();
        m_owner = -1; m_next = -1; m_beats = 0; m_in_turn = 0;
        m_hold_addr = '0; m_hold_wdata = '0;
    endtask

    task automatic expected_bus(output logic [31:0] a, output logic [31:0] w,
                                output logic [1:0] s, output logic wr);
        if (m_in_turn) begin
            a = m_hold_addr; w = m_hold_wdata; s = 2'b00; wr = 1'b0;
        end else if (m_owner >= 0) begin
            a = dma_addr[m_owner*32 +: 32]; w = dma_wdata[m_owner*32 +: 32];
            s = dma_size[m_owner*2 +: 2];   wr = dma_write[m_owner];
        end else begin
            a = cpu_addr; w = cpu_wdata; s = cpu_size; wr = cpu_write;
        end
    endtask

    task automatic check_all();
        logic [31:0] a, w;
        logic [1:0]  s;
        logic        wr;
        logic [N-1:0] g;
        expected_bus(a, w, s, wr);
        g = (m_owner >= 0) ? N'(1 << m_owner) : '0;
        check_eq("bus_addr", bus_addr, a);
        check_eq("bus_wdata", bus_wdata, w);
        check_eq("bus_size", bus_size, s);
        check_eq("bus_write", bus_write, wr);
        check_eq("dma_grant", dma_grant, g);
        check_eq("beat_done", beat_done, !m_in_turn && !bus_pause);
        check_eq("dma_active", dma_active, m_in_turn || m_owner >= 0);
        check_eq("beat_count", beat_count, m_beats);
    endtask

    task automatic model_step();
        logic [31:0] a, w;
        logic [1:0]  s;
        logic        wr;
        int          h;
        expected_bus(a, w, s, wr);
        h = highest(dma_req);
        if (!m_in_turn) begin
            m_hold_addr = a; m_hold_wdata = w;
        end
        if (m_in_turn) begin
            m_in_turn = 0;
            m_owner = (m_next >= 0 && dma_req[m_next]) ? m_next : h;
            if (m_owner >= 0) m_beats = 0;
        end else if (m_owner < 0) begin
            if (h >= 0 && !bus_pause) begin
                m_in_turn = 1; m_next = h;
            end
        end else if (!bus_pause) begin
            if (m_beats < 65535) m_beats++;
            if ((h >= 0 && h < m_owner) || !dma_req[m_owner]) begin
                m_in_turn = 1; m_next = h; m_owner = -1;
            end
        end
    endtask

    task automatic cyc();
        @(negedge clock);
        check_all();
        @(posedge clock);
        model_step();
        #1;
    endtask

    task automatic randomize_data();
        cpu_addr = $urandom; cpu_wdata = $urandom;
        cpu_size = 2'($urandom_range(0, 3)); cpu_write = 1'($urandom_range(0, 1));
        for (int i = 0; i < int'(N); i++) begin
            dma_addr[i*32 +: 32]  = $urandom;
            dma_wdata[i*32 +: 32] = $urandom;
            dma_size[i*2 +: 2]    = 2'($urandom_range(0, 3));
            dma_write[i]          = 1'($urandom_range(0, 1));
        end
    endtask

    task automatic fixed_data();
        cpu_addr = 32'h0300_0000; cpu_wdata = 32'hC0DE_0000; cpu_size = 2'b10; cpu_write = 1'b1;
        for (int i = 0; i < int'(N); i++) begin
            dma_addr[i*32 +: 32]  = 32'hD0D0_0000 + 32'(i) * 32'h0303_0000;
            dma_wdata[i*32 +: 32] = 32'hAA00_0000 + 32'(i);
            dma_size[i*2 +: 2]    = 2'b01;
            dma_write[i]          = 1'b1;
        end
    endtask

    initial begin
        reset = 1'b1; dma_req = '0; bus_pause = 1'b0;
        fixed_data();
        model_reset();
        #3;
        check_eq("rst_grant", dma_grant, 4'b0000);
        check_eq("rst_active", dma_active, 1'b0);
        check_eq("rst_addr", bus_addr, 32'h0300_0000);
        check_eq("rst_count", beat_count, 0);
        @(posedge clock); #1;
        reset = 1'b0;

        // CPU beat stretched by pause while DMA3 requests
        bus_pause = 1'b1; dma_req = 4'b1000;
        repeat (3) begin
            cyc();
            check_eq("paused_cpu_active", dma_active, 1'b0);
        end
        bus_pause = 1'b0;
        cyc();
        check_eq("turn_write", bus_write, 1'b0);
        check_eq("turn_active", dma_active, 1'b1);
        cyc();
        check_eq("dma3_grant", dma_grant, 4'b1000);
        check_eq("dma3_addr", bus_addr, 32'hD9D9_0000);
        dma_req = 4'b0000;
        repeat (2) cyc();

        // Simultaneous DMA1 + DMA3: DMA1 wins and keeps the bus
        dma_req = 4'b1010;
        repeat (2) cyc();
        repeat (6) begin
            bus_pause = 1'($urandom_range(0, 1));
            check_eq("dma1_grant", dma_grant, 4'b0010);
            cyc();
        end
        check_eq("dma1_still", dma_grant, 4'b0010);
        bus_pause = 1'b0; dma_req = 4'b0000;
        repeat (3) cyc();

        // DMA3 burst preempted by DMA0 arriving mid-pause
        dma_req = 4'b1000;
        repeat (2) cyc();
        check_eq("burst_start_count", beat_count, 0);
        repeat (4) cyc();
        bus_pause = 1'b1; dma_req = 4'b1001;
        cyc();
        check_eq("held_grant", dma_grant, 4'b1000);
        bus_pause = 1'b0;
        cyc();
        check_eq("preempt_count", beat_count, 5);
        check_eq("preempt_turn_grant", dma_grant, 4'b0000);
        cyc();
        check_eq("dma0_grant", dma_grant, 4'b0001);
        check_eq("dma0_count", beat_count, 0);

        // Owner drops with nothing else pending
        dma_req = 4'b0000;
        cyc();
        check_eq("drop_turn_active", dma_active, 1'b1);
        cyc();
        check_eq("drop_cpu_active", dma_active, 1'b0);

        // Reset in the middle of a paused DMA2 beat
        dma_req = 4'b0100;
        repeat (2) cyc();
        check_eq("dma2_grant", dma_grant, 4'b0100);
        bus_pause = 1'b1;
        #2;
        reset = 1'b1;
        #1;
        check_eq("midrst_grant", dma_grant, 4'b0000);
        check_eq("midrst_active", dma_active, 1'b0);
        check_eq("midrst_addr", bus_addr, cpu_addr);
        check_eq("midrst_write", bus_write, cpu_write);
        check_eq("midrst_beat_done", beat_done, 1'b0);
        model_reset();
        @(posedge clock); #1;
        reset = 1'b0; bus_pause = 1'b0; dma_req = '0;

        // Random traffic with slowly varying request levels
        for (int c = 0; c < 2000; c++) begin
            randomize_data();
            for (int i = 0; i < int'(N); i++)
                if ($urandom_range(0, 7) == 0) dma_req[i] = ~dma_req[i];
            bus_pause = ($urandom_range(0, 2) == 0);
            cyc();
        end

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
